// File: rtl/preload_mem_ctrl.sv
// Single-port RAM controller that muxes a streaming preload engine and the CPU memory port.
// Optional running-XOR checksum of the preload stream is enabled with `define PRELOAD_CSUM_EN.
module preload_mem_ctrl #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic              pl_valid_i,
  input  logic [DATA_W-1:0] pl_data_i,
  output logic              pl_ready_o,
  input  logic              cpu_wen_i,
  input  logic              cpu_oen_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_cen_o,
  output logic              mem_wen_o,
  output logic              mem_oen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef PRELOAD_CSUM_EN
  ,
  input  logic [DATA_W-1:0] csum_exp_i
`endif
);

  localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OneLen   = {{ADDR_W{1'b0}}, 1'b1};

`ifdef PRELOAD_CSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad} state_e;
`endif

  state_e            state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic              busy_q;
  logic              done_q;
  logic              pl_ready_q;

  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W-1:0] load_addr;
  logic              handshake;
  logic              last_beat;

  // Lengths beyond the array size would only rewrite words already loaded.
  assign len_sat   = (length_i > DepthLen) ? DepthLen : length_i;
  assign load_addr = base_q + count_q[ADDR_W-1:0];
  assign handshake = (state_q == StLoad) && pl_valid_i && pl_ready_q;
  assign last_beat = (count_q == (len_q - OneLen));

`ifdef PRELOAD_CSUM_EN
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] csum_exp_q;
  logic              err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum_q     <= '0;
      csum_exp_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start_i) begin
        csum_q     <= '0;
        csum_exp_q <= csum_exp_i;
        err_q      <= 1'b0;
      end else if (handshake) begin
        csum_q <= csum_q ^ pl_data_i;
      end else if (state_q == StCheck) begin
        err_q <= (csum_q != csum_exp_q);
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      base_q     <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pl_ready_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            base_q  <= base_addr_i;
            len_q   <= len_sat;
            count_q <= '0;
            done_q  <= (len_sat == '0);
            if (len_sat != '0) begin
              state_q    <= StLoad;
              busy_q     <= 1'b1;
              pl_ready_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (handshake) begin
            count_q <= count_q + OneLen;
            if (last_beat) begin
              pl_ready_q <= 1'b0;
`ifdef PRELOAD_CSUM_EN
              state_q    <= StCheck;
`else
              state_q    <= StIdle;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end
          end
        end
`ifdef PRELOAD_CSUM_EN
        StCheck: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif
        default: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          pl_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM port: CPU passthrough when idle, preload stream otherwise.
  always_comb begin
    mem_addr_o = cpu_addr_i;
    mem_d_o    = cpu_wdata_i;
    mem_wen_o  = cpu_wen_i;
    mem_oen_o  = cpu_oen_i;
    if (state_q == StLoad) begin
      mem_addr_o = load_addr;
      mem_d_o    = pl_data_i;
      mem_wen_o  = ~pl_valid_i;
      mem_oen_o  = 1'b1;
    end else if (state_q != StIdle) begin
      mem_addr_o = load_addr;
      mem_d_o    = pl_data_i;
      mem_wen_o  = 1'b1;
      mem_oen_o  = 1'b1;
    end
    if (rst_i) begin
      mem_wen_o = 1'b1;
      mem_oen_o = 1'b1;
    end
  end

  assign mem_cen_o   = 1'b0;
  assign cpu_rdata_o = mem_q_i;
  assign cpu_stall_o = busy_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pl_ready_o  = pl_ready_q;

endmodule

// File: tb/tb_preload_mem_ctrl.sv
// Self-checking bench for preload_mem_ctrl with a behavioural synchronous RAM and a write scoreboard.
// Build with +define+PRELOAD_CSUM_EN to also exercise the checksum feature.
module tb_preload_mem_ctrl;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CsumCycles = `ifdef PRELOAD_CSUM_EN 1 `else 0 `endif;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          pl_valid;
  logic [DW-1:0] pl_data;
  logic          pl_ready;
  logic          cpu_wen;
  logic          cpu_oen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_cen;
  logic          mem_wen;
  logic          mem_oen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic          busy;
  logic          done;
  logic          err;
`ifdef PRELOAD_CSUM_EN
  logic [DW-1:0] csum_exp;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int stall_cnt = 0;
  int hs_cnt = 0;

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] words [16];

  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  logic [DW-1:0] exp_rd [$];

  preload_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_addr_i(base_addr),
    .length_i   (length),
    .pl_valid_i (pl_valid),
    .pl_data_i  (pl_data),
    .pl_ready_o (pl_ready),
    .cpu_wen_i  (cpu_wen),
    .cpu_oen_i  (cpu_oen),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .mem_cen_o  (mem_cen),
    .mem_wen_o  (mem_wen),
    .mem_oen_o  (mem_oen),
    .mem_addr_o (mem_addr),
    .mem_d_o    (mem_d),
    .mem_q_i    (mem_q),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
`ifdef PRELOAD_CSUM_EN
    ,
    .csum_exp_i (csum_exp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus monitors; all sample pre-edge values.
  always @(posedge clk) begin
    if (!mem_cen && !mem_wen) begin
      ram[mem_addr] <= mem_d;
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_d);
    end
    if (!mem_cen && !mem_oen) mem_q <= ram[mem_addr];
    if (busy) busy_cnt++;
    if (cpu_stall) stall_cnt++;
    if (pl_valid && pl_ready) hs_cnt++;
  end

  // Starts a load and streams words[]; expected writes are queued as each handshake is committed.
  task automatic drive_load(input logic [AW-1:0] b, input logic [AW:0] l, input int n,
                            input bit bubbles, input bit cpu_noise, input int abort_at);
    int idx = 0;
    int guard = 0;
    bit phase = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    busy_cnt = 0; stall_cnt = 0; hs_cnt = 0;
    while (idx < n && idx != abort_at && guard < 200) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (cpu_noise) begin
        cpu_wen = 1'b0; cpu_oen = 1'b0; cpu_addr = 11'h003; cpu_wdata = 32'hBAD0BAD0;
      end
      if (bubbles && phase) begin
        pl_valid = 1'b0;
      end else begin
        pl_valid = 1'b1;
        pl_data  = words[idx];
      end
      phase = ~phase;
      if (pl_valid && pl_ready) begin
        exp_addr.push_back(b + idx[AW-1:0]);
        exp_data.push_back(words[idx]);
        idx++;
      end
    end
    n_cmp++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL load_timeout: got %0d words accepted, required %0d", idx, n);
    end
    @(negedge clk);
    start = 1'b0; pl_valid = 1'b0; cpu_wen = 1'b1; cpu_oen = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; pl_valid = 1'b0; pl_data = '0;
    cpu_wen = 1'b0; cpu_oen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef PRELOAD_CSUM_EN
    csum_exp = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_wen !== 1'b1) begin n_err++; $display("FAIL rst_mem_wen: got %b required 1", mem_wen); end
    n_cmp++; if (mem_oen !== 1'b1) begin n_err++; $display("FAIL rst_mem_oen: got %b required 1", mem_oen); end
    n_cmp++; if (mem_cen !== 1'b0) begin n_err++; $display("FAIL rst_mem_cen: got %b required 0", mem_cen); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b required 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", err); end
    n_cmp++; if (pl_ready !== 1'b0) begin n_err++; $display("FAIL rst_pl_ready: got %b required 0", pl_ready); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b required 0", cpu_stall); end
    @(negedge clk);
    cpu_wen = 1'b1; cpu_oen = 1'b1; rst = 1'b0;
    obs_addr.delete(); obs_data.delete();
  endtask

  task automatic test_cpu_rw();
    @(negedge clk);
    cpu_wen = 1'b0; cpu_addr = 11'h005; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    cpu_wen = 1'b1; cpu_oen = 1'b0;
    exp_rd.push_back(32'hDEADBEEF);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_stall_idle: got %b required 0", cpu_stall); end
    @(negedge clk);
    cpu_oen = 1'b1;
    if (exp_rd.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_rd.pop_front();
      n_cmp++;
      if (cpu_rdata !== e) begin n_err++; $display("FAIL cpu_read: got %h required %h", cpu_rdata, e); end
    end
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 11'h005 || obs_data[0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL cpu_write: got %0d writes, required 1 write of deadbeef at 005", obs_addr.size());
    end
    obs_addr.delete(); obs_data.delete();
  endtask

  task automatic test_load_basic();
    for (int i = 0; i < 4; i++) words[i] = i + 1;
    drive_load(11'h010, 12'd4, 4, 1'b0, 1'b0, -1);
    repeat (CsumCycles) @(negedge clk);
    n_cmp++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL basic_wr_count: got %0d required %0d", obs_addr.size(), exp_addr.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] ea, oa;
      logic [DW-1:0] ed, od;
      ea = exp_addr.pop_front(); ed = exp_data.pop_front();
      oa = obs_addr.pop_front(); od = obs_data.pop_front();
      n_cmp++;
      if (oa !== ea || od !== ed) begin
        n_err++; $display("FAIL basic_wr: got %h@%h required %h@%h", od, oa, ed, ea);
      end
    end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    n_cmp++; if (busy_cnt != 4 + CsumCycles) begin n_err++; $display("FAIL basic_busy_cycles: got %0d required %0d", busy_cnt, 4 + CsumCycles); end
    n_cmp++; if (stall_cnt != 4 + CsumCycles) begin n_err++; $display("FAIL basic_stall_cycles: got %0d required %0d", stall_cnt, 4 + CsumCycles); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b required 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b required 0", busy); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL basic_stall_after: got %b required 0", cpu_stall); end
    cpu_oen = 1'b0; cpu_addr = 11'h012;
    exp_rd.push_back(32'd3);
    @(negedge clk);
    cpu_oen = 1'b1;
    if (exp_rd.size() > 0) begin
      logic [DW-1:0] e;
      e = exp_rd.pop_front();
      n_cmp++;
      if (cpu_rdata !== e) begin n_err++; $display("FAIL basic_readback: got %h required %h", cpu_rdata, e); end
    end
  endtask

  task automatic test_wrap_bubbles();
    for (int i = 0; i < 4; i++) words[i] = 32'hA0 + i + 1;
    drive_load(11'h7FE, 12'd4, 4, 1'b1, 1'b1, -1);
    repeat (CsumCycles) @(negedge clk);
    n_cmp++;
    if (obs_addr.size() != 4) begin
      n_err++; $display("FAIL wrap_wr_count: got %0d required 4", obs_addr.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      logic [AW-1:0] ea, oa;
      logic [DW-1:0] ed, od;
      ea = exp_addr.pop_front(); ed = exp_data.pop_front();
      oa = obs_addr.pop_front(); od = obs_data.pop_front();
      n_cmp++;
      if (oa !== ea || od !== ed) begin
        n_err++; $display("FAIL wrap_wr: got %h@%h required %h@%h", od, oa, ed, ea);
      end
    end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    n_cmp++; if (hs_cnt != 4) begin n_err++; $display("FAIL wrap_handshakes: got %0d required 4", hs_cnt); end
    n_cmp++; if (busy_cnt != 7 + CsumCycles) begin n_err++; $display("FAIL wrap_busy_cycles: got %0d required %0d", busy_cnt, 7 + CsumCycles); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b required 1", done); end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1; base_addr = 11'h020; length = '0; busy_cnt = 0;
    obs_addr.delete(); obs_data.delete();
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b required 1", done); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL zero_busy: got %0d busy cycles required 0", busy_cnt); end
    n_cmp++; if (obs_addr.size() != 0) begin n_err++; $display("FAIL zero_writes: got %0d required 0", obs_addr.size()); end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 8; i++) words[i] = 32'hC0DE0000 + i;
    drive_load(11'h040, 12'd8, 8, 1'b0, 1'b0, 2);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b required 0", done); end
    n_cmp++; if (pl_ready !== 1'b0) begin n_err++; $display("FAIL midrst_pl_ready: got %b required 0", pl_ready); end
    n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b required 0", cpu_stall); end
    n_cmp++;
    if (obs_addr.size() != 2) begin n_err++; $display("FAIL midrst_wr_count: got %0d required 2", obs_addr.size()); end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    @(negedge clk);
    rst = 1'b0;
    words[0] = 32'h00000055;
    drive_load(11'h100, 12'd1, 1, 1'b0, 1'b0, -1);
    repeat (CsumCycles) @(negedge clk);
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 11'h100 || obs_data[0] !== 32'h55) begin
      n_err++; $display("FAIL midrst_reload_wr: got %0d writes, required 1 write of 55 at 100", obs_addr.size());
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL midrst_reload_done: got %b required 1", done); end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
  endtask

`ifdef PRELOAD_CSUM_EN
  task automatic test_csum();
    words[0] = 32'hA; words[1] = 32'h5;
    csum_exp = 32'hF;
    drive_load(11'h200, 12'd2, 2, 1'b0, 1'b0, -1);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL csum_ok_done: got %b required 1", done); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL csum_ok_err: got %b required 0", err); end
    csum_exp = 32'h0;
    drive_load(11'h200, 12'd2, 2, 1'b0, 1'b0, -1);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL csum_bad_done: got %b required 1", done); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL csum_bad_err: got %b required 1", err); end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_rw();
    test_load_basic();
    test_wrap_bubbles();
    test_zero_len();
    test_reset_mid_load();
`ifdef PRELOAD_CSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
